// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
//   Types and constants shared by the bit serializer and the downstream
//   sequence-detector stage.
//
//   ser_state_t        : serializer FSM state (idle / shifting a word out)
//   SER_DEFAULT_WIDTH  : default parallel word width of the serializer
// -----------------------------------------------------------------------------
package seq_pkg;

  localparam int SER_DEFAULT_WIDTH = 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

endpackage : seq_pkg

// File: rtl/bit_serializer_if.sv
// -----------------------------------------------------------------------------
// bit_serializer_if
//   Parallel-word valid/ready handshake feeding the bit serializer.
//
//   in_data  : parallel word (WIDTH bits), source -> serializer
//   in_valid : in_data holds a word,       source -> serializer
//   in_ready : serializer accepts in_data, serializer -> source
//
//   Modports:
//     master : the word source
//     slave  : the serializer
// -----------------------------------------------------------------------------
interface bit_serializer_if
  import seq_pkg::*;
#(
  parameter int WIDTH = SER_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface : bit_serializer_if

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//   Accepts WIDTH-bit words over a valid/ready handshake and shifts them out
//   one bit per cycle. The output stream is intended for the in_bit input of
//   the sequence-detector stage.
//
//   Parameters
//     WIDTH     : parallel word width, 2..32
//     MSB_FIRST : 1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
//     IDLE_BIT  : level driven on out_bit while no word is in flight
//
//   Ports
//     clk       : single clock, all state changes on the rising edge
//     rst       : synchronous, active-high reset
//     in_bus    : slave side of the word handshake (in_data/in_valid/in_ready)
//     pause     : freezes shifting (state, counter, shift register) while high
//     out_bit   : serial data
//     out_valid : out_bit carries a new bit this cycle
//     busy      : a word is in flight
//
//   Timing
//     The first bit of a word appears the cycle after the accepting edge.
//     in_ready is also raised on the last bit of a word, so a word offered
//     at that point follows the previous one with no idle cycle in between.
// -----------------------------------------------------------------------------
module bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = SER_DEFAULT_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  bit_serializer_if.slave   in_bus,
  input  logic              pause,
  output logic              out_bit,
  output logic              out_valid,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ser_state_t       state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic             advance;   // a bit is consumed this cycle
  logic             last_bit;  // the bit on out_bit is the last of the word
  logic             ready;
  logic             transfer;
  logic [WIDTH-1:0] shift_d;   // shift register after consuming one bit
  logic             cur_bit;   // bit currently at the output end

  always_comb begin
    // NOTE: every signal driven here gets a value on every path (defaults
    // first); a path that leaves one unassigned would infer a latch.
    shift_d = shift_q;
    cur_bit = shift_q[0];
    if (MSB_FIRST) begin
      shift_d = {shift_q[WIDTH-2:0], 1'b0};
      cur_bit = shift_q[WIDTH-1];
    end else begin
      shift_d = {1'b0, shift_q[WIDTH-1:1]};
      cur_bit = shift_q[0];
    end

    advance  = (state_q == S_SHIFT) && !pause;
    last_bit = (cnt_q == LAST_IDX);

    // Ready when idle, or while the last bit of the current word is being
    // consumed; pause on the last bit blocks the hand-over as well. Held low
    // during reset so nothing is accepted that the reset would then discard.
    ready    = !rst && ((state_q == S_IDLE) || (advance && last_bit));
    transfer = in_bus.in_valid && ready;
  end

  assign in_bus.in_ready = ready;

  // ---------------------------------------------------------------------------
  // FSM, shift register and bit counter
  // ---------------------------------------------------------------------------
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others; blocking assignments
  // would make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      // NOTE: the shift register is pure datapath and would not normally need
      // a reset; it is cleared so that no bit of a word interrupted by reset
      // can surface afterwards, and so the idle contents are deterministic.
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (transfer) begin
            shift_q <= in_bus.in_data;
            cnt_q   <= '0;
            state_q <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (!pause) begin
            if (last_bit) begin
              if (transfer) begin
                // Back-to-back reload: next word's first bit is on out_bit
                // in the very next cycle.
                shift_q <= in_bus.in_data;
                cnt_q   <= '0;
              end else begin
                // Counter is left at WIDTH-1; it only wraps on a reload.
                state_q <= S_IDLE;
              end
            end else begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // out_bit comes straight from the shift register, so it holds naturally
  // while paused and falls back to IDLE_BIT as soon as the word completes.
  assign busy      = (state_q == S_SHIFT);
  assign out_valid = advance;
  assign out_bit   = busy ? cur_bit : IDLE_BIT;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_cnt_range : assert property (@(posedge clk) disable iff (rst)
    cnt_q <= LAST_IDX);

  a_valid_busy : assert property (@(posedge clk) disable iff (rst)
    out_valid |-> busy);

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//   Directed bench for bit_serializer. Two instances share clk/rst:
//     dut_m : WIDTH=8, MSB_FIRST=1, IDLE_BIT=0
//     dut_l : WIDTH=8, MSB_FIRST=0, IDLE_BIT=1
//   Inputs change 1 time unit after a rising edge; outputs are sampled on the
//   falling edge. Status tuples are packed as {in_ready, out_valid, busy,
//   out_bit}.
// -----------------------------------------------------------------------------
module tb_bit_serializer;
  import seq_pkg::*;

  localparam int W = SER_DEFAULT_WIDTH;

  logic clk = 1'b0;
  logic rst;
  logic pause_m, pause_l;
  logic ob_m, ov_m, busy_m;
  logic ob_l, ov_l, busy_l;

  int checks = 0;
  int errors = 0;

  bit_serializer_if #(.WIDTH(W)) bus_m ();
  bit_serializer_if #(.WIDTH(W)) bus_l ();

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk       (clk),
    .rst       (rst),
    .in_bus    (bus_m.slave),
    .pause     (pause_m),
    .out_bit   (ob_m),
    .out_valid (ov_m),
    .busy      (busy_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
    .clk       (clk),
    .rst       (rst),
    .in_bus    (bus_l.slave),
    .pause     (pause_l),
    .out_bit   (ob_l),
    .out_valid (ov_l),
    .busy      (busy_l)
  );

  wire [3:0] st_m = {bus_m.in_ready, ov_m, busy_m, ob_m};
  wire [3:0] st_l = {bus_l.in_ready, ov_l, busy_l, ob_l};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst            = 1'b1;
    pause_m        = 1'b0;
    pause_l        = 1'b0;
    bus_m.in_valid = 1'b1;
    bus_m.in_data  = 8'hAA;
    bus_l.in_valid = 1'b1;
    bus_l.in_data  = 8'h55;
    next_cycle();
    next_cycle();
    sample();
    checks++;
    if (st_m !== 4'b0000) begin
      errors++;
      $display("FAIL reset_msb: got %b expected %b", st_m, 4'b0000);
    end
    checks++;
    if (st_l !== 4'b0001) begin
      errors++;
      $display("FAIL reset_lsb: got %b expected %b", st_l, 4'b0001);
    end
    // Words offered during reset must have been dropped.
    next_cycle();
    rst            = 1'b0;
    bus_m.in_valid = 1'b0;
    bus_l.in_valid = 1'b0;
    sample();
    checks++;
    if (st_m !== 4'b1000) begin
      errors++;
      $display("FAIL post_reset_msb: got %b expected %b", st_m, 4'b1000);
    end
    checks++;
    if (st_l !== 4'b1001) begin
      errors++;
      $display("FAIL post_reset_lsb: got %b expected %b", st_l, 4'b1001);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single();
    logic [7:0] word;
    logic [3:0] exp;
    logic [3:0] hist;
    int         det;
    word = 8'hB0;
    hist = 4'b0000;
    det  = 0;
    next_cycle();
    bus_m.in_data  = word;
    bus_m.in_valid = 1'b1;
    sample();
    checks++;
    if (st_m !== 4'b1000) begin
      errors++;
      $display("FAIL b0_accept: got %b expected %b", st_m, 4'b1000);
    end
    next_cycle();
    bus_m.in_valid = 1'b0;
    bus_m.in_data  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sample();
      exp = {(i == 7), 1'b1, 1'b1, word[7-i]};
      checks++;
      if (st_m !== exp) begin
        errors++;
        $display("FAIL b0_bit%0d: got %b expected %b", i, st_m, exp);
      end
      // Bench-side overlapping detector for the pattern 1011.
      if (ov_m === 1'b1) begin
        hist = {hist[2:0], ob_m};
        if (hist == 4'b1011) det++;
      end
      next_cycle();
    end
    sample();
    checks++;
    if (st_m !== 4'b1000) begin
      errors++;
      $display("FAIL b0_idle: got %b expected %b", st_m, 4'b1000);
    end
    checks++;
    if (det != 1) begin
      errors++;
      $display("FAIL b0_detect: got %0d detections expected 1", det);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [15:0] stream;
    logic [3:0]  exp;
    stream = {8'hB5, 8'h6D};
    next_cycle();
    bus_m.in_data  = 8'hB5;
    bus_m.in_valid = 1'b1;
    sample();
    checks++;
    if (st_m !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_accept: got %b expected %b", st_m, 4'b1000);
    end
    next_cycle();
    bus_m.in_data = 8'h6D;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) bus_m.in_valid = 1'b0;
      sample();
      exp = {(i == 7 || i == 15), 1'b1, 1'b1, stream[15-i]};
      checks++;
      if (st_m !== exp) begin
        errors++;
        $display("FAIL b2b_bit%0d: got %b expected %b", i, st_m, exp);
      end
      next_cycle();
    end
    sample();
    checks++;
    if (st_m !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_idle: got %b expected %b", st_m, 4'b1000);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_pause();
    logic [7:0] word;
    logic [7:0] got;
    logic [3:0] exp;
    int         nvalid;
    word   = 8'hF0;
    got    = 8'h00;
    nvalid = 0;
    next_cycle();
    bus_m.in_data  = word;
    bus_m.in_valid = 1'b1;
    sample();
    next_cycle();
    bus_m.in_valid = 1'b0;
    // 3 bits, 2 paused cycles, 5 bits, then idle.
    for (int c = 0; c < 11; c++) begin
      pause_m = (c == 3 || c == 4);
      sample();
      if (c == 3 || c == 4) begin
        exp = {1'b0, 1'b0, 1'b1, word[4]};
        checks++;
        if (st_m !== exp) begin
          errors++;
          $display("FAIL pause_hold%0d: got %b expected %b", c, st_m, exp);
        end
      end else if (c == 10) begin
        checks++;
        if (st_m !== 4'b1000) begin
          errors++;
          $display("FAIL pause_idle: got %b expected %b", st_m, 4'b1000);
        end
      end
      if (ov_m === 1'b1) begin
        got = {got[6:0], ob_m};
        nvalid++;
      end
      next_cycle();
    end
    pause_m = 1'b0;
    checks++;
    if (nvalid != 8) begin
      errors++;
      $display("FAIL pause_count: got %0d valid bits expected 8", nvalid);
    end
    checks++;
    if (got !== word) begin
      errors++;
      $display("FAIL pause_stream: got %h expected %h", got, word);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_pause_last();
    logic [7:0] w0;
    logic [7:0] w1;
    logic [3:0] exp;
    w0 = 8'h81;
    w1 = 8'h3C;
    next_cycle();
    bus_m.in_data  = w0;
    bus_m.in_valid = 1'b1;
    sample();
    next_cycle();
    bus_m.in_data = w1;
    for (int c = 0; c < 10; c++) begin
      pause_m = (c == 7 || c == 8);
      sample();
      if (c < 7)       exp = {1'b0, 1'b1, 1'b1, w0[7-c]};
      else if (c < 9)  exp = {1'b0, 1'b0, 1'b1, w0[0]};
      else             exp = {1'b1, 1'b1, 1'b1, w0[0]};
      checks++;
      if (st_m !== exp) begin
        errors++;
        $display("FAIL plast_c%0d: got %b expected %b", c, st_m, exp);
      end
      next_cycle();
    end
    pause_m        = 1'b0;
    bus_m.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      exp = {(i == 7), 1'b1, 1'b1, w1[7-i]};
      checks++;
      if (st_m !== exp) begin
        errors++;
        $display("FAIL plast_next%0d: got %b expected %b", i, st_m, exp);
      end
      next_cycle();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    int late;
    late = 0;
    next_cycle();
    bus_m.in_data  = 8'hFF;
    bus_m.in_valid = 1'b1;
    sample();
    next_cycle();
    bus_m.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      checks++;
      if (st_m !== 4'b0111) begin
        errors++;
        $display("FAIL rmid_bit%0d: got %b expected %b", i, st_m, 4'b0111);
      end
      next_cycle();
    end
    rst = 1'b1;
    sample();
    checks++;
    if (bus_m.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_ready: got %b expected 0", bus_m.in_ready);
    end
    next_cycle();
    rst = 1'b0;
    sample();
    checks++;
    if (st_m !== 4'b1000) begin
      errors++;
      $display("FAIL rmid_after: got %b expected %b", st_m, 4'b1000);
    end
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      sample();
      if (ov_m !== 1'b0) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL rmid_leftover: got %0d late bits expected 0", late);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_lsb_first();
    logic [7:0] word;
    logic [3:0] exp;
    word = 8'h0D;
    next_cycle();
    bus_l.in_data  = word;
    bus_l.in_valid = 1'b1;
    sample();
    checks++;
    if (st_l !== 4'b1001) begin
      errors++;
      $display("FAIL lsb_accept: got %b expected %b", st_l, 4'b1001);
    end
    next_cycle();
    bus_l.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      exp = {(i == 7), 1'b1, 1'b1, word[i]};
      checks++;
      if (st_l !== exp) begin
        errors++;
        $display("FAIL lsb_bit%0d: got %b expected %b", i, st_l, exp);
      end
      next_cycle();
    end
    sample();
    checks++;
    if (st_l !== 4'b1001) begin
      errors++;
      $display("FAIL lsb_idle: got %b expected %b", st_l, 4'b1001);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ignore_busy();
    logic [15:0] stream;
    logic [3:0]  exp;
    stream = {8'hA5, 8'h3C};
    next_cycle();
    bus_m.in_data  = 8'hA5;
    bus_m.in_valid = 1'b1;
    sample();
    next_cycle();
    for (int i = 0; i < 16; i++) begin
      if (i == 7)       bus_m.in_data = 8'h3C;
      else              bus_m.in_data = 8'(8'hC3 + i * 29);
      bus_m.in_valid = (i != 15);
      sample();
      exp = {(i == 7 || i == 15), 1'b1, 1'b1, stream[15-i]};
      checks++;
      if (st_m !== exp) begin
        errors++;
        $display("FAIL ign_bit%0d: got %b expected %b", i, st_m, exp);
      end
      next_cycle();
    end
    bus_m.in_valid = 1'b0;
    sample();
    checks++;
    if (st_m !== 4'b1000) begin
      errors++;
      $display("FAIL ign_idle: got %b expected %b", st_m, 4'b1000);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_pause();
    test_pause_last();
    test_reset_mid();
    test_lsb_first();
    test_ignore_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bit_serializer
